// File: rtl/fsm_pkg.sv
// Shared definitions for the bit-stream source and its downstream detector.
//   state_t   : frame sequencer states (IDLE / SHIFT / DONE, 2-bit)
//   WIDTH_DEF : default word width in bits
//   DIV_DEF   : default number of clock cycles each bit is held
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DIV_DEF   = 4;

endpackage

// File: rtl/bit_tick_div.sv
// Bit-period divider: a down-counter that marks the last cycle of a bit slot.
//   clk    : system clock
//   reset  : asynchronous active-low reset (count clears to 0)
//   i_load : reload the counter with DIV-1 (start of a new bit slot)
//   o_tick : high while the count is 0, i.e. the current bit slot ends at the next edge
module bit_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_tick
);

    generate
        if (DIV == 1) begin : g_bypass
            // Every cycle is the last cycle of its bit slot.
            logic w_unused;
            assign w_unused = ^{clk, reset, i_load};
            assign o_tick   = 1'b1;
        end else begin : g_count
            localparam int unsigned   CW     = $clog2(DIV);
            localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (i_load) begin
                    r_cnt <= RELOAD;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign o_tick = (r_cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/bit_stream_gen.sv
// Parallel-to-serial source feeding the consecutive-ones detector.
// Accepts a WIDTH-bit word on a valid/ready handshake, shifts it out MSB-first
// on wo holding each bit for DIV cycles, then pulses done for one cycle.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   din       : parallel word, sampled only on handshake
//   din_valid : producer has a word on din
//   din_ready : high only in IDLE
//   wo        : registered serial output (to detector wi)
//   busy      : high in SHIFT and DONE
//   done      : one-cycle pulse after the last bit of a word
module bit_stream_gen
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIV   = DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             wo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    // The MSB goes straight to wo at the handshake, so only the remaining
    // WIDTH-1 bits need to be held; wo always takes the top bit of this register.
    logic [WIDTH-2:0] r_shreg;
    logic [WIDTH-2:0] w_shreg_nxt;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    w_bit_cnt_nxt;
    logic             r_wo;
    logic             w_wo_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_load;
    logic             w_tick;

    bit_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_wo      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_wo      <= w_wo_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_wo_nxt      = r_wo;
        w_done_nxt    = 1'b0;
        w_load        = 1'b0;

        case (r_state)
            IDLE: begin
                w_wo_nxt = 1'b0;
                if (din_valid) begin
                    w_load        = 1'b1;
                    w_shreg_nxt   = din[WIDTH-2:0];
                    w_bit_cnt_nxt = BW'(WIDTH - 1);
                    w_wo_nxt      = din[WIDTH-1];
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_bit_cnt != '0) begin
                        w_load        = 1'b1;
                        w_wo_nxt      = r_shreg[WIDTH-2];
                        w_shreg_nxt   = r_shreg << 1;
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                    end else begin
                        w_wo_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_wo_nxt    = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_wo_nxt    = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign din_ready = (r_state == IDLE);
    assign busy      = (r_state == SHIFT) || (r_state == DONE);
    assign wo        = r_wo;
    assign done      = r_done;

endmodule

// File: tb/tb_bit_stream_gen.sv
// Bench for bit_stream_gen: two instances (DIV=1 and DIV=4, WIDTH=8) checked
// every cycle against a frame-timing model, plus directed literal checks.
module tb_bit_stream_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [2];
    logic [1:0] vld;
    logic [1:0] rdy;
    logic [1:0] wo;
    logic [1:0] busy;
    logic [1:0] done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    bit_stream_gen #(.WIDTH(8), .DIV(1)) u_div1 (
        .clk(clk), .reset(rst_n), .din(din[0]), .din_valid(vld[0]),
        .din_ready(rdy[0]), .wo(wo[0]), .busy(busy[0]), .done(done[0])
    );

    bit_stream_gen #(.WIDTH(8), .DIV(4)) u_div4 (
        .clk(clk), .reset(rst_n), .din(din[1]), .din_valid(vld[1]),
        .din_ready(rdy[1]), .wo(wo[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame accepted at edge N: bit k on wo in cycles N+1+k*D .. N+(k+1)*D,
    // done in cycle N+8*D+1, idle (ready) from cycle N+8*D+2 on.
    bit          act   [2];
    int unsigned hs    [2];
    logic [7:0]  mword [2];
    int unsigned cyc = 0;

    function automatic int unsigned divof(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic void model_out(input int i, input int unsigned c,
                                      output logic w, output logic b,
                                      output logic d, output logic r);
        int unsigned dv;
        int unsigned off;
        dv = divof(i);
        w = 1'b0; b = 1'b0; d = 1'b0; r = 1'b1;
        if (act[i] && c > hs[i]) begin
            off = c - hs[i];
            if (off <= 8 * dv) begin
                w = mword[i][7 - (off - 1) / dv];
                b = 1'b1;
                r = 1'b0;
            end else if (off == 8 * dv + 1) begin
                d = 1'b1;
                b = 1'b1;
                r = 1'b0;
            end
        end
    endfunction

    // Edge number cyc ends spec cycle cyc; outputs after it belong to cycle cyc+1.
    always @(posedge clk) begin
        logic mw, mb, md, mr;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0;
            end else begin
                model_out(i, cyc, mw, mb, md, mr);
                if (mr && vld[i]) begin
                    act[i]   = 1'b1;
                    hs[i]    = cyc;
                    mword[i] = din[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic mw, mb, md, mr;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                model_out(i, cyc + 1, mw, mb, md, mr);
                chk($sformatf("model_wo%0d", i),    32'(wo[i]),   32'(mw));
                chk($sformatf("model_busy%0d", i),  32'(busy[i]), 32'(mb));
                chk($sformatf("model_done%0d", i),  32'(done[i]), 32'(md));
                chk($sformatf("model_ready%0d", i), 32'(rdy[i]),  32'(mr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!rdy[i] && n < 300) begin
            tick();
            n++;
        end
        chk($sformatf("ready_timeout%0d", i), 32'(rdy[i]), 32'd1);
    endtask

    // Returns in the first cycle after the handshake edge (bit 0 on wo).
    task automatic send(input int i, input logic [7:0] word);
        wait_ready(i);
        din[i] = word;
        vld[i] = 1'b1;
        tick();
        vld[i] = 1'b0;
    endtask

    initial begin
        logic [7:0]  cap;
        logic [17:0] cap18;
        int unsigned ones;
        int unsigned gap;

        vld    = '0;
        din[0] = '0;
        din[1] = '0;
        rst_n  = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_wo",    32'(wo[i]),   32'd0);
            chk("rst_busy",  32'(busy[i]), 32'd0);
            chk("rst_done",  32'(done[i]), 32'd0);
            chk("rst_ready", 32'(rdy[i]),  32'd1);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_wo",    32'(wo[0]),  32'd0);
        chk("idle_ready", 32'(rdy[0]), 32'd1);

        // Single word, DIV=1
        send(0, 8'hE7);
        cap = '0;
        for (int j = 1; j <= 8; j++) begin
            cap = {cap[6:0], wo[0]};
            tick();
        end
        chk("e7_bits",     32'(cap),     32'h0000_00E7);
        chk("e7_done_c9",  32'(done[0]), 32'd1);
        tick();
        chk("e7_ready_c10", 32'(rdy[0]), 32'd1);
        chk("e7_done_off",  32'(done[0]), 32'd0);

        // Bit hold, DIV=4
        send(1, 8'h80);
        ones = 0;
        for (int j = 1; j <= 32; j++) begin
            if (j <= 4) chk("hold_lead_one", 32'(wo[1]), 32'd1);
            ones += 32'(wo[1]);
            tick();
        end
        chk("hold_ones",     ones,             32'd4);
        chk("hold_done_c33", 32'(done[1]),     32'd1);

        // Back-to-back with din_valid held high, DIV=1
        wait_ready(0);
        din[0] = 8'hFF;
        vld[0] = 1'b1;
        tick();
        din[0] = 8'h01;
        cap18  = '0;
        gap    = 0;
        for (int j = 1; j <= 18; j++) begin
            cap18 = {cap18[16:0], wo[0]};
            if (rdy[0] && gap == 0) gap = j;
            if (j == 11) vld[0] = 1'b0;
            tick();
        end
        chk("b2b_spacing", gap,         32'd10);
        chk("b2b_stream",  32'(cap18),  32'(18'b111111110000000001));
        wait_ready(0);

        // Ignored din/din_valid during SHIFT, DIV=4
        send(1, 8'hA5);
        cap = '0;
        for (int j = 1; j <= 32; j++) begin
            if (j % 4 == 2) cap = {cap[6:0], wo[1]};
            if (j == 6) begin
                din[1] = 8'h00;
                vld[1] = 1'b1;
            end
            if (j == 7) vld[1] = 1'b0;
            tick();
        end
        chk("ignore_word", 32'(cap), 32'h0000_00A5);
        wait_ready(1);

        // Reset in the middle of bit 3 of 8'hAA, DIV=4
        send(1, 8'hAA);
        repeat (13) tick();
        chk("pre_rst_busy", 32'(busy[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wo",    32'(wo[1]),   32'd0);
        chk("midrst_busy",  32'(busy[1]), 32'd0);
        chk("midrst_done",  32'(done[1]), 32'd0);
        chk("midrst_ready", 32'(rdy[1]),  32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        send(1, 8'h55);
        cap = '0;
        for (int j = 1; j <= 32; j++) begin
            if (j % 4 == 2) cap = {cap[6:0], wo[1]};
            tick();
        end
        chk("post_rst_word", 32'(cap), 32'h0000_0055);
        wait_ready(1);

        // Randomized traffic on both instances, with one reset pulse
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 2) != 0);
                din[i] = 8'($urandom);
            end
            if (n == 1500) rst_n = 1'b0;
            if (n == 1503) rst_n = 1'b1;
            tick();
        end
        vld = '0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
